flappy_frame_renderer: RTL
==========================

// Module: flappy_frame_renderer
// PURPOSE
// Pixel renderer fed by the flappy_bird_control system's exported game state
// (bird_x/bird_y, pipe_x, pipe1..pipe5, level). Captures that state into shadow
// registers once per frame, so a mid-frame CPU write cannot tear the image. A
// 2-stage pipeline classifies each pixel as bird, pipe, ground or sky, emits RGB,
// and reports a per-frame bird/pipe overlap flag.
// PARAMETERS
// H_RES        640  visible width; pipe columns starting at x >= H_RES are skipped
// BIRD_SIZE    16   bird square edge, in pixels
// PIPE_W       48   pipe column width, in pixels
// PIPE_SPACING 160  x distance between consecutive pipes
// GAP_H        96   vertical gap height, in pixels
// GROUND_Y     440  first ground row
// PORTS
// clk_clk        in   1   system clock
// reset_reset_n  in   1   asynchronous, active-low reset
// pix_en         in   1   pixel strobe; draw_x/draw_y are valid on this cycle
// draw_x         in   10  current pixel column
// draw_y         in   10  current pixel row
// frame_start    in   1   1-cycle pulse at start of vertical blank
// bird_x         in   16  bird left edge
// bird_y         in   16  bird top edge
// pipe_x         in   16  pipe1 left edge
// pipe1..pipe5   in   16  each  gap top row for pipes 1..5
// level          in   16  only [1:0] used; selects sky palette
// rgb_valid      out  1   red/green/blue are valid
// red/green/blue out  8   each  pixel colour
// layer          out  2   0=sky, 1=ground, 2=pipe, 3=bird
// collide        out  1   bird overlapped a pipe during the previous frame
// BEHAVIOUR
// - Reset: all shadows, pipeline registers, outputs, collision accumulator = 0.
// - Shadow capture: on a frame_start clock edge, every input state word is
//   loaded into its shadow register. All inputs are ignored at any other time.
// - Pipe k (k = 1..5) left edge = pipe_x + (k-1)*PIPE_SPACING, computed in
//   17 bits with no wrap. Pipe k is disabled when its left edge >= H_RES.
// - Stage 1 (pix_en cycle): register the following comparisons, each zero-extended
//   to 17 bits:
//     bird_hit = bird_x <= x < bird_x+BIRD_SIZE  &&  bird_y <= y < bird_y+BIRD_SIZE
//     pipe_hit = OR over enabled k of (pk_x <= x < pk_x+PIPE_W)
//                  && !(gap_k <= y < gap_k+GAP_H)
//     gnd_hit  = y >= GROUND_Y
// - Stage 2: priority bird > pipe > ground > sky.
//     Colours: bird FFD800, pipe 30B030, ground C08040.
//     Sky by level[1:0]: 0=70C0F0, 1=4090D0, 2=F08040, 3=202050.
// - Latency: rgb_valid pulses exactly 2 cycles after pix_en, with 1-cycle
//   throughput. Pixels without pix_en produce rgb_valid=0, and red/green/blue/layer
//   hold their last values.
// - Collision: stage 2 sets the sticky accumulator when bird_hit && pipe_hit
//   (any gnd_hit state). On frame_start: collide <= accumulator; accumulator <=
//   this cycle's stage-2 overlap. collide holds until the next frame_start.
// - frame_start together with pix_en: the pixel uses the old shadows; the new
//   shadows apply from the next cycle.
// - Reset asserted mid-frame: pipeline flushed, collide=0, shadows=0; nothing is
//   drawn from stale state after release.
// TESTING
// - Reset, then frame_start with bird (100,200), pixel (108,205)
//     -> 2 cycles later rgb_valid=1, FFD800, layer=3.
// - pipe_x=300, pipe2=150, pixel (470,100)
//     -> pipe 30B030.
//   Pixel (470,200) with level=1
//     -> sky 4090D0.
// - pipe_x=600: pixel (620,0)
//     -> pipe colour.
//   Pipes 2..5 (760+) disabled, pixel (10,0)
//     -> sky.
// - Bird (300,10) on pipe1 (pipe_x=300, pipe1=200), overlap pixels streamed,
//   frame_start
//     -> collide=1.
//   A following clean frame
//     -> collide=0.
// - Change bird_x mid-frame without frame_start
//     -> rendering unchanged until the next frame_start.
// - Pixel at y=440 with no bird/pipe
//     -> C08040, layer=1.
//   Assert reset_reset_n=0 during streaming
//     -> outputs 0 immediately.

Source files
------------

// File: rtl/flappy_frame_renderer.sv
// rtl/flappy_frame_renderer.sv - two-stage pixel classifier/colourer with per-frame shadowed game state
module flappy_frame_renderer #(
    parameter int H_RES        = 640,
    parameter int BIRD_SIZE    = 16,
    parameter int PIPE_W       = 48,
    parameter int PIPE_SPACING = 160,
    parameter int GAP_H        = 96,
    parameter int GROUND_Y     = 440
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        pix_en,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        frame_start,
    input  logic [15:0] bird_x,
    input  logic [15:0] bird_y,
    input  logic [15:0] pipe_x,
    input  logic [15:0] pipe1,
    input  logic [15:0] pipe2,
    input  logic [15:0] pipe3,
    input  logic [15:0] pipe4,
    input  logic [15:0] pipe5,
    input  logic [15:0] level,
    output logic        rgb_valid,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [1:0]  layer,
    output logic        collide
);
    localparam logic [23:0] BIRD_RGB   = 24'hFFD800;
    localparam logic [23:0] PIPE_RGB   = 24'h30B030;
    localparam logic [23:0] GROUND_RGB = 24'hC08040;

    logic [15:0] sh_bird_x, sh_bird_y, sh_pipe_x;
    logic [15:0] sh_gap [5];
    logic [1:0]  sh_level;

    logic        s1_valid, s1_bird, s1_pipe, s1_gnd;
    logic [1:0]  s1_level;
    logic        coll_acc;

    logic [16:0] px, py;
    logic [16:0] left_k, gap_k;
    logic        bird_hit_c, pipe_hit_c, gnd_hit_c;
    logic [23:0] pix_rgb;
    logic [1:0]  pix_layer;
    logic        overlap;
    logic        unused_level;

    assign unused_level = ^level[15:2];
    assign px = {7'd0, draw_x};
    assign py = {7'd0, draw_y};

    // All comparisons in 17 bits so right/bottom edges near 16'hFFFF never wrap.
    always_comb begin
        left_k     = '0;
        gap_k      = '0;
        pipe_hit_c = 1'b0;
        bird_hit_c = ({1'b0, sh_bird_x} <= px) && (px < {1'b0, sh_bird_x} + 17'(BIRD_SIZE)) &&
                     ({1'b0, sh_bird_y} <= py) && (py < {1'b0, sh_bird_y} + 17'(BIRD_SIZE));
        gnd_hit_c  = py >= 17'(GROUND_Y);
        for (int k = 0; k < 5; k++) begin
            left_k = {1'b0, sh_pipe_x} + 17'(k * PIPE_SPACING);
            gap_k  = {1'b0, sh_gap[k]};
            if ((left_k < 17'(H_RES)) && (left_k <= px) && (px < left_k + 17'(PIPE_W)) &&
                !((gap_k <= py) && (py < gap_k + 17'(GAP_H))))
                pipe_hit_c = 1'b1;
        end
    end

    always_comb begin
        pix_rgb   = 24'h70C0F0;
        pix_layer = 2'd0;
        if (s1_bird) begin
            pix_rgb   = BIRD_RGB;
            pix_layer = 2'd3;
        end else if (s1_pipe) begin
            pix_rgb   = PIPE_RGB;
            pix_layer = 2'd2;
        end else if (s1_gnd) begin
            pix_rgb   = GROUND_RGB;
            pix_layer = 2'd1;
        end else begin
            case (s1_level)
                2'd0:    pix_rgb = 24'h70C0F0;
                2'd1:    pix_rgb = 24'h4090D0;
                2'd2:    pix_rgb = 24'hF08040;
                default: pix_rgb = 24'h202050;
            endcase
        end
    end

    assign overlap = s1_valid && s1_bird && s1_pipe;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sh_bird_x <= '0;
            sh_bird_y <= '0;
            sh_pipe_x <= '0;
            sh_level  <= '0;
            for (int k = 0; k < 5; k++) sh_gap[k] <= '0;
        end else if (frame_start) begin
            sh_bird_x <= bird_x;
            sh_bird_y <= bird_y;
            sh_pipe_x <= pipe_x;
            sh_level  <= level[1:0];
            sh_gap[0] <= pipe1;
            sh_gap[1] <= pipe2;
            sh_gap[2] <= pipe3;
            sh_gap[3] <= pipe4;
            sh_gap[4] <= pipe5;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid  <= 1'b0;
            s1_bird   <= 1'b0;
            s1_pipe   <= 1'b0;
            s1_gnd    <= 1'b0;
            s1_level  <= '0;
            rgb_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            layer     <= '0;
            collide   <= 1'b0;
            coll_acc  <= 1'b0;
        end else begin
            s1_valid  <= pix_en;
            if (pix_en) begin
                s1_bird  <= bird_hit_c;
                s1_pipe  <= pipe_hit_c;
                s1_gnd   <= gnd_hit_c;
                s1_level <= sh_level;
            end
            rgb_valid <= s1_valid;
            if (s1_valid) begin
                red   <= pix_rgb[23:16];
                green <= pix_rgb[15:8];
                blue  <= pix_rgb[7:0];
                layer <= pix_layer;
            end
            // An overlap landing on the frame_start edge belongs to the new frame.
            if (frame_start) begin
                collide  <= coll_acc;
                coll_acc <= overlap;
            end else if (overlap) begin
                coll_acc <= 1'b1;
            end
        end
    end
endmodule
